// File: rtl/typing_game_pkg.sv
// Shared types for the keyboard reaction game: FSM state encoding and default key codes.
// No logic here; latency and backpressure are not applicable.
package typing_game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DRAW     = 3'd1,
      ST_PLAY     = 3'd2,
      ST_WAIT_REL = 3'd3,
      ST_WIN      = 3'd4,
      ST_LOSS     = 3'd5
   } game_state_e;

   localparam int DEF_RELEASE_CODE = 21;

endpackage

// File: rtl/key_event_det.sv
// Key edge detector: flags a change of decoder code as a press or a release event.
// Events are combinational against a registered last code; no backpressure, sampled every cycle.
module key_event_det #(
   parameter int KEY_W        = 5,
   parameter int RELEASE_CODE = typing_game_pkg::DEF_RELEASE_CODE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] key_code,
   output logic             press_evt,
   output logic             release_evt,
   output logic [KEY_W-1:0] code
);

   localparam logic [KEY_W-1:0] REL = KEY_W'(RELEASE_CODE);

   logic [KEY_W-1:0] last_q, last_d;
   logic             change;

   always_comb begin
      last_d      = key_code;
      change      = (key_code != last_q);
      press_evt   = change && (key_code != REL);
      release_evt = change && (key_code == REL);
      code        = key_code;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= REL;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/typing_game_ctrl.sv
// Multi-round reaction game controller: draws a letter, times the player, judges the key, tracks score/lives.
// All outputs registered, judgement visible 1 cycle after the key event; no backpressure, inputs sampled every cycle.
module typing_game_ctrl
   import typing_game_pkg::*;
#(
   parameter int NUM_LETTERS   = 26,
   parameter int KEY_W         = 5,
   parameter int RELEASE_CODE  = DEF_RELEASE_CODE,
   parameter int SEQ_LEN       = 8,
   parameter int LIVES         = 3,
   parameter int TIMEOUT_TICKS = 2000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [KEY_W-1:0]               key_code,
   input  logic [KEY_W-1:0]               rand_val,
   input  logic                           tick,
   output logic [2:0]                     state,
   output logic [KEY_W-1:0]               goal,
   output logic                           timer_en,
   output logic                           timer_clr,
   output logic [$clog2(SEQ_LEN+1)-1:0]   round,
   output logic [$clog2(SEQ_LEN+1)-1:0]   score,
   output logic [$clog2(LIVES+1)-1:0]     lives,
   output logic                           hit,
   output logic                           miss,
   output logic                           win,
   output logic                           loss
);

   localparam int RND_W = $clog2(SEQ_LEN+1);
   localparam int LIV_W = $clog2(LIVES+1);
   localparam int CNT_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS+1) : 1;

   localparam logic [RND_W-1:0] SEQ_MAX  = RND_W'(SEQ_LEN);
   localparam logic [LIV_W-1:0] LIV_INIT = LIV_W'(LIVES);
   localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT_TICKS);

   logic             press_evt, release_evt;
   logic [KEY_W-1:0] code;

   key_event_det #(
      .KEY_W        (KEY_W),
      .RELEASE_CODE (RELEASE_CODE)
   ) u_key_evt (
      .clk         (clk),
      .rst         (rst),
      .key_code    (key_code),
      .press_evt   (press_evt),
      .release_evt (release_evt),
      .code        (code)
   );

   game_state_e      state_q, state_d;
   logic [KEY_W-1:0] goal_q, goal_d;
   logic [RND_W-1:0] round_q, round_d;
   logic [RND_W-1:0] score_q, score_d;
   logic [LIV_W-1:0] lives_q, lives_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hit_q, hit_d;
   logic             miss_q, miss_d;
   logic             timer_en_q, timer_clr_q, win_q, loss_q;
   logic [CNT_W-1:0] cnt_inc;
   logic             timeout;
   logic             rand_ok;

   always_comb begin
      state_d = state_q;
      goal_d  = goal_q;
      round_d = round_q;
      score_d = score_q;
      lives_d = lives_q;
      cnt_d   = cnt_q;
      hit_d   = 1'b0;
      miss_d  = 1'b0;
      timeout = 1'b0;
      cnt_inc = cnt_q + CNT_W'(1);
      rand_ok = (int'(rand_val) < NUM_LETTERS);

      case (state_q)
         ST_IDLE, ST_WIN, ST_LOSS: begin
            if (release_evt) begin
               round_d = '0;
               score_d = '0;
               lives_d = LIV_INIT;
               state_d = ST_DRAW;
            end
         end
         ST_DRAW: begin
            if (rand_ok) begin
               goal_d  = rand_val;
               cnt_d   = '0;
               state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (tick && (TIMEOUT_TICKS != 0)) begin
               cnt_d   = cnt_inc;
               timeout = (cnt_inc == TO_VAL);
            end
            // A press wins over a coinciding terminal tick, so a round is judged once.
            if (press_evt || timeout) begin
               if (press_evt && (code == goal_q)) begin
                  hit_d = 1'b1;
                  if (score_q != SEQ_MAX) score_d = score_q + RND_W'(1);
               end else begin
                  miss_d = 1'b1;
                  if (lives_q != '0) lives_d = lives_q - LIV_W'(1);
               end
               if (round_q != SEQ_MAX) round_d = round_q + RND_W'(1);

               if (lives_d == '0)          state_d = ST_LOSS;
               else if (round_d == SEQ_MAX) state_d = ST_WIN;
               else if (press_evt)          state_d = ST_WAIT_REL;
               else                         state_d = ST_DRAW;
            end
         end
         ST_WAIT_REL: begin
            if (release_evt) state_d = ST_DRAW;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         goal_q      <= '0;
         round_q     <= '0;
         score_q     <= '0;
         lives_q     <= LIV_INIT;
         cnt_q       <= '0;
         hit_q       <= 1'b0;
         miss_q      <= 1'b0;
         timer_en_q  <= 1'b0;
         timer_clr_q <= 1'b0;
         win_q       <= 1'b0;
         loss_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         goal_q      <= goal_d;
         round_q     <= round_d;
         score_q     <= score_d;
         lives_q     <= lives_d;
         cnt_q       <= cnt_d;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
         timer_en_q  <= (state_d == ST_PLAY);
         timer_clr_q <= (state_d == ST_DRAW) && (state_q != ST_DRAW);
         win_q       <= (state_d == ST_WIN);
         loss_q      <= (state_d == ST_LOSS);
      end
   end

   assign state     = state_q;
   assign goal      = goal_q;
   assign round     = round_q;
   assign score     = score_q;
   assign lives     = lives_q;
   assign hit       = hit_q;
   assign miss      = miss_q;
   assign timer_en  = timer_en_q;
   assign timer_clr = timer_clr_q;
   assign win       = win_q;
   assign loss      = loss_q;

endmodule

// File: tb/tb_typing_game_ctrl.sv
// Bench for typing_game_ctrl: directed vector table, hand-written corner sequences and a random run
// checked every cycle against a rule-level game model.
module tb_typing_game_ctrl;

   localparam int NL  = 26;
   localparam int KW  = 5;
   localparam int REL = 21;
   localparam int SEQ = 3;
   localparam int LV  = 2;
   localparam int TO  = 3;

   localparam int M_IDLE = 0, M_DRAW = 1, M_PLAY = 2, M_WAIT = 3, M_WIN = 4, M_LOSS = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [KW-1:0] key_code = KW'(REL);
   logic [KW-1:0] rand_val = '0;
   logic          tick = 1'b0;
   logic [2:0]    state;
   logic [KW-1:0] goal;
   logic          timer_en, timer_clr, hit, miss, win, loss;
   logic [1:0]    round, score, lives;

   always #5 clk = ~clk;

   typing_game_ctrl #(
      .NUM_LETTERS   (NL),
      .KEY_W         (KW),
      .RELEASE_CODE  (REL),
      .SEQ_LEN       (SEQ),
      .LIVES         (LV),
      .TIMEOUT_TICKS (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_code  (key_code),
      .rand_val  (rand_val),
      .tick      (tick),
      .state     (state),
      .goal      (goal),
      .timer_en  (timer_en),
      .timer_clr (timer_clr),
      .round     (round),
      .score     (score),
      .lives     (lives),
      .hit       (hit),
      .miss      (miss),
      .win       (win),
      .loss      (loss)
   );

   int errors = 0;
   int checks = 0;

   // Reference game: what the player has achieved so far, in plain integers.
   int m_state, m_goal, m_round, m_score, m_lives, m_ticks, m_last;
   int e_hit, e_miss, e_clr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_step(input bit r, input int k, input int rv, input bit t);
      bit press, release_k, judged;
      int prev;
      e_hit  = 0;
      e_miss = 0;
      e_clr  = 0;
      if (r) begin
         m_state = M_IDLE; m_goal = 0; m_round = 0; m_score = 0;
         m_lives = LV; m_ticks = 0; m_last = REL;
         return;
      end
      press     = (k != m_last) && (k != REL);
      release_k = (k != m_last) && (k == REL);
      prev      = m_state;
      if (m_state == M_IDLE || m_state == M_WIN || m_state == M_LOSS) begin
         if (release_k) begin
            m_round = 0; m_score = 0; m_lives = LV; m_state = M_DRAW;
         end
      end else if (m_state == M_DRAW) begin
         if (rv < NL) begin
            m_goal = rv; m_ticks = 0; m_state = M_PLAY;
         end
      end else if (m_state == M_PLAY) begin
         if (t) m_ticks++;
         judged = press || (TO != 0 && t && m_ticks >= TO);
         if (judged) begin
            if (press && k == m_goal) begin
               e_hit = 1;
               m_score = (m_score + 1 > SEQ) ? SEQ : m_score + 1;
            end else begin
               e_miss = 1;
               m_lives = m_lives - 1;
            end
            m_round = (m_round + 1 > SEQ) ? SEQ : m_round + 1;
            if (m_lives == 0)        m_state = M_LOSS;
            else if (m_round == SEQ) m_state = M_WIN;
            else if (press)          m_state = M_WAIT;
            else                     m_state = M_DRAW;
         end
      end else if (m_state == M_WAIT) begin
         if (release_k) m_state = M_DRAW;
      end
      e_clr  = (m_state == M_DRAW && prev != M_DRAW) ? 1 : 0;
      m_last = k;
   endtask

   task automatic cycle(input bit r, input int k, input int rv, input bit t);
      @(negedge clk);
      rst      = r;
      key_code = KW'(k);
      rand_val = KW'(rv);
      tick     = t;
      @(posedge clk);
      #1;
      model_step(r, k, rv, t);
      check("state",     32'(state),     32'(m_state));
      check("goal",      32'(goal),      32'(m_goal));
      check("round",     32'(round),     32'(m_round));
      check("score",     32'(score),     32'(m_score));
      check("lives",     32'(lives),     32'(m_lives));
      check("hit",       32'(hit),       32'(e_hit));
      check("miss",      32'(miss),      32'(e_miss));
      check("timer_clr", 32'(timer_clr), 32'(e_clr));
      check("timer_en",  32'(timer_en),  32'(m_state == M_PLAY));
      check("win",       32'(win),       32'(m_state == M_WIN));
      check("loss",      32'(loss),      32'(m_state == M_LOSS));
   endtask

   typedef struct {
      bit r; int k; int rv; bit t;
      int st; int g; int rd; int sc; int lv; bit h; bit m; bit en; bit clr;
   } vec_t;

   vec_t tbl[23];

   initial begin
      int cur_key;
      //         r  key rnd t   st  g  rd sc lv h m en clr
      tbl[0]  = '{1, 21,  0, 0,  0,  0, 0, 0, 2, 0,0,0,0};
      tbl[1]  = '{0,  3,  0, 0,  0,  0, 0, 0, 2, 0,0,0,0};
      tbl[2]  = '{0, 21,  0, 0,  1,  0, 0, 0, 2, 0,0,0,1};
      tbl[3]  = '{0, 21, 30, 0,  1,  0, 0, 0, 2, 0,0,0,0};
      tbl[4]  = '{0, 21,  7, 0,  2,  7, 0, 0, 2, 0,0,1,0};
      tbl[5]  = '{0,  7,  0, 0,  3,  7, 1, 1, 2, 1,0,0,0};
      tbl[6]  = '{0,  7,  0, 0,  3,  7, 1, 1, 2, 0,0,0,0};
      tbl[7]  = '{0,  9,  0, 0,  3,  7, 1, 1, 2, 0,0,0,0};
      tbl[8]  = '{0, 21,  0, 0,  1,  7, 1, 1, 2, 0,0,0,1};
      tbl[9]  = '{0, 21,  2, 0,  2,  2, 1, 1, 2, 0,0,1,0};
      tbl[10] = '{0,  5,  0, 0,  3,  2, 2, 1, 1, 0,1,0,0};
      tbl[11] = '{0, 21,  0, 0,  1,  2, 2, 1, 1, 0,0,0,1};
      tbl[12] = '{0, 21, 25, 0,  2, 25, 2, 1, 1, 0,0,1,0};
      tbl[13] = '{0, 25,  0, 0,  4, 25, 3, 2, 1, 1,0,0,0};
      tbl[14] = '{0, 21,  0, 0,  1, 25, 0, 0, 2, 0,0,0,1};
      tbl[15] = '{0, 21, 26, 0,  1, 25, 0, 0, 2, 0,0,0,0};
      tbl[16] = '{0, 21,  0, 0,  2,  0, 0, 0, 2, 0,0,1,0};
      tbl[17] = '{0, 21,  0, 1,  2,  0, 0, 0, 2, 0,0,1,0};
      tbl[18] = '{0, 21,  0, 1,  2,  0, 0, 0, 2, 0,0,1,0};
      tbl[19] = '{0, 21,  0, 1,  1,  0, 1, 0, 1, 0,1,0,1};
      tbl[20] = '{0, 21,  4, 0,  2,  4, 1, 0, 1, 0,0,1,0};
      tbl[21] = '{0,  6,  0, 1,  5,  4, 2, 0, 0, 0,1,0,0};
      tbl[22] = '{0,  6,  0, 0,  5,  4, 2, 0, 0, 0,0,0,0};

      for (int i = 0; i < 23; i++) begin
         cycle(tbl[i].r, tbl[i].k, tbl[i].rv, tbl[i].t);
         check($sformatf("tbl%0d.state", i), 32'(state),     32'(tbl[i].st));
         check($sformatf("tbl%0d.goal", i),  32'(goal),      32'(tbl[i].g));
         check($sformatf("tbl%0d.round", i), 32'(round),     32'(tbl[i].rd));
         check($sformatf("tbl%0d.score", i), 32'(score),     32'(tbl[i].sc));
         check($sformatf("tbl%0d.lives", i), 32'(lives),     32'(tbl[i].lv));
         check($sformatf("tbl%0d.hit", i),   32'(hit),       32'(tbl[i].h));
         check($sformatf("tbl%0d.miss", i),  32'(miss),      32'(tbl[i].m));
         check($sformatf("tbl%0d.ten", i),   32'(timer_en),  32'(tbl[i].en));
         check($sformatf("tbl%0d.tclr", i),  32'(timer_clr), 32'(tbl[i].clr));
         check($sformatf("tbl%0d.win", i),   32'(win),       32'(tbl[i].st == 4));
         check($sformatf("tbl%0d.loss", i),  32'(loss),      32'(tbl[i].st == 5));
      end

      // Press coinciding with the terminal tick: judged once, on the key.
      cycle(0, 21,  0, 0);
      cycle(0, 21, 10, 0);
      cycle(0, 21,  0, 1);
      cycle(0, 21,  0, 1);
      cycle(0, 10,  0, 1);
      check("simul_hit.hit",   32'(hit),   32'd1);
      check("simul_hit.miss",  32'(miss),  32'd0);
      check("simul_hit.state", 32'(state), 32'd3);
      cycle(0, 10,  0, 1);
      check("simul_hit.no_late_miss", 32'(miss), 32'd0);
      cycle(0, 21,  5, 0);
      cycle(0, 21,  5, 0);
      cycle(0, 21,  0, 1);
      cycle(0, 21,  0, 1);
      cycle(0,  9,  0, 1);
      check("simul_miss.miss",  32'(miss),  32'd1);
      check("simul_miss.lives", 32'(lives), 32'd1);
      check("simul_miss.state", 32'(state), 32'd3);

      // Rejected draws, then a valid one; repeated presses in WAIT_REL are not judged.
      cycle(1, 21, 0, 0);
      cycle(0,  3, 0, 0);
      cycle(0, 21, 30, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 21, 30, 0);
         check($sformatf("reject%0d.state", i), 32'(state), 32'd1);
      end
      cycle(0, 21, 4, 0);
      check("rearm.goal",  32'(goal),  32'd4);
      check("rearm.state", 32'(state), 32'd2);
      cycle(0, 4, 0, 0);
      check("rearm.hit", 32'(hit), 32'd1);
      cycle(0, 9, 0, 0);
      cycle(0, 4, 0, 0);
      check("waitrel.hit",   32'(hit),   32'd0);
      check("waitrel.miss",  32'(miss),  32'd0);
      check("waitrel.score", 32'(score), 32'd1);

      // Reset in the middle of PLAY.
      cycle(0, 21, 0, 0);
      cycle(0, 21, 8, 0);
      check("midplay.state", 32'(state), 32'd2);
      cycle(1, 12, 0, 0);
      check("rst.state", 32'(state), 32'd0);
      check("rst.score", 32'(score), 32'd0);
      check("rst.lives", 32'(lives), 32'(LV));
      check("rst.hit",   32'(hit),   32'd0);
      check("rst.miss",  32'(miss),  32'd0);

      cur_key = 12;
      for (int i = 0; i < 3000; i++) begin
         int k, sel, rv;
         bit t, r;
         sel = int'($urandom_range(0, 9));
         if (sel < 4)      k = cur_key;
         else if (sel < 6) k = REL;
         else if (sel < 8) k = m_goal;
         else              k = int'($urandom_range(0, 31));
         rv = int'($urandom_range(0, 31));
         t  = ($urandom_range(0, 2) == 0);
         r  = ($urandom_range(0, 499) == 0);
         cycle(r, k, rv, t);
         cur_key = k;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
